// File: rtl/pipe_ctrl_hazard_unit.sv
// Control pipeline (ID/EX, EX/MEM, MEM/WB) with hazard stall, forwarding selects and sticky ecall halt.
// Optional macro FORWARDING_EN: load-use stall plus EX/MEM and MEM/WB forwarding; otherwise stall until producer leaves MEM.
module pipe_ctrl_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_mem_read,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_write,
  input  logic                  id_alu_src,
  input  logic                  id_write_enable,
  input  logic                  id_pc_to_reg,
  input  logic                  id_is_ecall,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_x17_is_10,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ex_alu_src,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_write_enable,
  output logic                  wb_mem_to_reg,
  output logic                  wb_pc_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  halt,
  output logic [CNT_W-1:0]      stall_count
);

  // ID/EX stage
  logic ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_we, ex_pc_to_reg, ex_ecall, ex_x17;
  // EX/MEM stage
  logic m_mem_to_reg, m_we, m_pc_to_reg, m_ecall, m_x17;

  logic stall, hold;

  function automatic logic src_hit(input logic we, input logic [REG_ADDR_W-1:0] rd,
                                   input logic u1, input logic [REG_ADDR_W-1:0] r1,
                                   input logic u2, input logic [REG_ADDR_W-1:0] r2);
    return we && (rd != '0) && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
  endfunction

  logic hit_ex;
  assign hit_ex = src_hit(ex_we, ex_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);

`ifdef FORWARDING_EN
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2;
  logic                  ex_use1, ex_use2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      ex_use1 <= 1'b0;
      ex_use2 <= 1'b0;
    end else if (hold) begin
      ex_rs1  <= '0;
      ex_rs2  <= '0;
      ex_use1 <= 1'b0;
      ex_use2 <= 1'b0;
    end else begin
      ex_rs1  <= id_rs1;
      ex_rs2  <= id_rs2;
      ex_use1 <= id_use_rs1;
      ex_use2 <= id_use_rs2;
    end
  end

  // Only a load in EX cannot be forwarded in time.
  assign stall = ex_mem_read && hit_ex;

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (src_hit(m_we, mem_rd, ex_use1, ex_rs1, 1'b0, ex_rs1))
      fwd_a = 2'b01;
    else if (src_hit(wb_write_enable, wb_rd, ex_use1, ex_rs1, 1'b0, ex_rs1))
      fwd_a = 2'b10;
    if (src_hit(m_we, mem_rd, ex_use2, ex_rs2, 1'b0, ex_rs2))
      fwd_b = 2'b01;
    else if (src_hit(wb_write_enable, wb_rd, ex_use2, ex_rs2, 1'b0, ex_rs2))
      fwd_b = 2'b10;
  end
`else
  logic hit_mem;
  // WB producers are excluded: the register file writes before it reads.
  assign hit_mem = src_hit(m_we, mem_rd, id_use_rs1, id_rs1, id_use_rs2, id_rs2);
  assign stall   = hit_ex || hit_mem;
  assign fwd_a   = 2'b00;
  assign fwd_b   = 2'b00;
`endif

  assign hold       = stall || halt;
  assign pc_write   = !hold;
  assign ifid_write = !hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_mem_read     <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_we           <= 1'b0;
      ex_pc_to_reg    <= 1'b0;
      ex_ecall        <= 1'b0;
      ex_x17          <= 1'b0;
      ex_rd           <= '0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      m_mem_to_reg    <= 1'b0;
      m_we            <= 1'b0;
      m_pc_to_reg     <= 1'b0;
      m_ecall         <= 1'b0;
      m_x17           <= 1'b0;
      mem_rd          <= '0;
      wb_write_enable <= 1'b0;
      wb_mem_to_reg   <= 1'b0;
      wb_pc_to_reg    <= 1'b0;
      wb_rd           <= '0;
      halt            <= 1'b0;
      stall_count     <= '0;
    end else begin
      ex_mem_read     <= hold ? 1'b0 : id_mem_read;
      ex_mem_to_reg   <= hold ? 1'b0 : id_mem_to_reg;
      ex_mem_write    <= hold ? 1'b0 : id_mem_write;
      ex_alu_src      <= hold ? 1'b0 : id_alu_src;
      ex_we           <= hold ? 1'b0 : id_write_enable;
      ex_pc_to_reg    <= hold ? 1'b0 : id_pc_to_reg;
      ex_ecall        <= hold ? 1'b0 : id_is_ecall;
      ex_x17          <= hold ? 1'b0 : id_x17_is_10;
      ex_rd           <= hold ? '0   : id_rd;
      mem_read        <= ex_mem_read;
      mem_write       <= ex_mem_write;
      m_mem_to_reg    <= ex_mem_to_reg;
      m_we            <= ex_we;
      m_pc_to_reg     <= ex_pc_to_reg;
      m_ecall         <= ex_ecall;
      m_x17           <= ex_x17;
      mem_rd          <= ex_rd;
      wb_write_enable <= m_we;
      wb_mem_to_reg   <= m_mem_to_reg;
      wb_pc_to_reg    <= m_pc_to_reg;
      wb_rd           <= mem_rd;
      // Halt rises on the edge the terminating ecall enters MEM/WB.
      if (m_ecall && m_x17)
        halt <= 1'b1;
      if (stall && !halt && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
